// File: rtl/pe_out_requant.sv
// Output stage behind the Winograd PE array: buffers result beats, requantises every lane and streams tiles out.
// Optional saturated-lane statistics are built when the QUANT_STATS_EN macro is defined.
module pe_out_requant #(
    parameter int OUT_BIT     = 24,
    parameter int DATA_BIT    = 8,
    parameter int RESULT_SIZE = 2,
    parameter int X_PE        = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_BIT   = 5
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic                                          poolop,
    input  logic [OUT_BIT*RESULT_SIZE*RESULT_SIZE*X_PE-1:0] result_unpool,
    input  logic [OUT_BIT*X_PE-1:0]                       result_pool,
    input  logic [SHIFT_BIT-1:0]                          shift,
    input  logic                                          relu_en,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_BIT*X_PE-1:0]                      out_data,
    output logic [1:0]                                    out_pos,
    output logic                                          out_last,
    output logic                                          almost_full,
    output logic                                          overflow,
    output logic [15:0]                                   sat_count
);
    localparam int RS2 = RESULT_SIZE * RESULT_SIZE;
    localparam int DW  = OUT_BIT * RS2 * X_PE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic signed [OUT_BIT:0] SAT_MAX = (OUT_BIT+1)'((2**(DATA_BIT-1)) - 1);
    localparam logic signed [OUT_BIT:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

    // Round-half-up shift, optional ReLU, then clip; returns {clipped, lane}.
    function automatic logic [DATA_BIT:0] requant(input logic [OUT_BIT-1:0] x,
                                                  input logic [SHIFT_BIT-1:0] sh,
                                                  input logic relu);
        logic signed [OUT_BIT:0] xe;
        logic signed [OUT_BIT:0] rnd;
        logic signed [OUT_BIT:0] v;
        logic                    sat;
        xe  = {x[OUT_BIT-1], x};
        rnd = '0;
        sat = 1'b0;
        if (sh == '0) begin
            v = xe;
        end else if (sh >= SHIFT_BIT'(OUT_BIT)) begin
            v = {(OUT_BIT+1){x[OUT_BIT-1]}};
        end else begin
            rnd = (OUT_BIT+1)'(1) <<< (sh - SHIFT_BIT'(1));
            v   = (xe + rnd) >>> sh;
        end
        if (relu && v[OUT_BIT]) begin
            v = '0;
        end else begin
            v = v;
        end
        if (v > SAT_MAX) begin
            v   = SAT_MAX;
            sat = 1'b1;
        end else if (v < SAT_MIN) begin
            v   = SAT_MIN;
            sat = 1'b1;
        end else begin
            sat = 1'b0;
        end
        return {sat, v[DATA_BIT-1:0]};
    endfunction

    logic [DW-1:0]        mem_data  [FIFO_DEPTH];
    logic [SHIFT_BIT-1:0] mem_shift [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_pool, mem_relu;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, src_idx_s;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d, almost_full_q, almost_full_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [1:0]            out_pos_q, out_pos_d, src_pos_s;
    logic [DATA_BIT*X_PE-1:0] out_data_q, out_data_d, lane_data_s;
    logic [X_PE-1:0]       lane_sat_s;
    logic [DW-1:0]         wdata_s;
    logic                  hs_s, pop_s, wr_s, load_s, clear_s;

    // Pooled results land in tile slot 0 of every PE.
    always_comb begin
        wdata_s = '0;
        if (poolop) begin
            for (int i = 0; i < X_PE; i++) begin
                wdata_s[i*RS2*OUT_BIT +: OUT_BIT] = result_pool[i*OUT_BIT +: OUT_BIT];
            end
        end else begin
            wdata_s = result_unpool;
        end
    end

    // FIFO bookkeeping and emit FSM; a full FIFO still accepts when the head retires this cycle.
    always_comb begin
        hs_s      = out_valid_q && out_ready;
        pop_s     = hs_s && out_last_q;
        wr_s      = in_valid && ((count_q < CW'(FIFO_DEPTH)) || pop_s);
        wr_ptr_d  = wr_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(wr_s) - CW'(pop_s);
        overflow_d    = overflow_q || (in_valid && !wr_s);
        almost_full_d = (count_d >= CW'(FIFO_DEPTH - 1));
        state_d   = state_q;
        load_s    = 1'b0;
        clear_s   = 1'b0;
        src_idx_s = rd_ptr_q;
        src_pos_s = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    load_s  = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (pop_s) begin
                    if (count_q >= CW'(2)) begin
                        load_s    = 1'b1;
                        src_idx_s = rd_ptr_q + AW'(1);
                    end else begin
                        clear_s = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (hs_s) begin
                    load_s    = 1'b1;
                    src_pos_s = out_pos_q + 2'd1;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Requantise every lane of the selected beat.
    always_comb begin
        lane_data_s = '0;
        lane_sat_s  = '0;
        for (int i = 0; i < X_PE; i++) begin
            {lane_sat_s[i], lane_data_s[i*DATA_BIT +: DATA_BIT]} =
                requant(mem_data[src_idx_s][(i*RS2 + int'(src_pos_s))*OUT_BIT +: OUT_BIT],
                        mem_shift[src_idx_s], mem_relu[src_idx_s]);
        end
    end

    // Output register next-state: load a new beat, drop valid on the final handshake, else hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_pos_d   = out_pos_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (load_s) begin
            out_data_d  = lane_data_s;
            out_pos_d   = src_pos_s;
            out_last_d  = mem_pool[src_idx_s] || (src_pos_s == 2'(RS2 - 1));
            out_valid_d = 1'b1;
        end else if (clear_s) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Beat storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_data[wr_ptr_q]  <= wdata_s;
            mem_shift[wr_ptr_q] <= shift;
            mem_pool[wr_ptr_q]  <= poolop;
            mem_relu[wr_ptr_q]  <= relu_en;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            almost_full_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pos_q     <= 2'd0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            almost_full_q <= almost_full_d;
            out_valid_q   <= out_valid_d;
            out_pos_q     <= out_pos_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_pos     = out_pos_q;
    assign out_last    = out_last_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

`ifdef QUANT_STATS_EN
    logic [X_PE-1:0] sat_lanes_q, sat_lanes_d;
    logic [15:0]     sat_count_q, sat_count_d;
    logic [16:0]     sat_sum_s;

    // Clip flags travel with the output beat; the counter adds them on handshake and sticks at all-ones.
    always_comb begin
        sat_lanes_d = load_s ? lane_sat_s : sat_lanes_q;
        sat_sum_s   = {1'b0, sat_count_q};
        for (int i = 0; i < X_PE; i++) begin
            sat_sum_s = sat_sum_s + 17'(sat_lanes_q[i]);
        end
        if (hs_s) begin
            sat_count_d = sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_lanes_q <= '0;
            sat_count_q <= 16'h0000;
        end else begin
            sat_lanes_q <= sat_lanes_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_sat_s;
    assign unused_sat_s = ^lane_sat_s;
    assign sat_count    = 16'h0000;
`endif

endmodule
